// File: rtl/tribus_pkg.sv
// Shared types for the tristate bus arbiter.
package tribus_pkg;

    // Arbiter FSM states, 2-bit encoding.
    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDrive = 2'd1,
        StTurn  = 2'd2
    } state_e;

endpackage

// File: rtl/tribus_rr_pick.sv
// Combinational round-robin winner selection: rotate requests so the slot after
// the last owner sits at bit 0, take the lowest set bit, then rotate the index back.
module tribus_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_last,
    output logic          o_valid,
    output logic [IW-1:0] o_winner,
    output logic [N-1:0]  o_onehot
);

    logic [IW:0]    w_shift;
    logic [2*N-1:0] w_dbl;
    logic [2*N-1:0] w_shifted;
    logic [N-1:0]   w_rot;
    logic [IW-1:0]  w_ofs;
    logic [IW+1:0]  w_sum;

    assign w_shift   = {1'b0, i_last} + {{IW{1'b0}}, 1'b1};
    assign w_dbl     = {i_req, i_req};
    assign w_shifted = w_dbl >> w_shift;
    assign w_rot     = w_shifted[N-1:0];
    assign o_valid   = |i_req;

    // Lowest set bit of the rotated vector (scan downward so the lowest wins).
    always_comb begin
        w_ofs = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (w_rot[i]) begin
                w_ofs = IW'(i);
            end
        end
    end

    // Undo the rotation: winner = (offset + last + 1) mod N.
    always_comb begin
        w_sum = {2'b00, w_ofs} + {1'b0, w_shift};
        if (w_sum >= (IW + 2)'(N)) begin
            w_sum = w_sum - (IW + 2)'(N);
        end
        o_winner = w_sum[IW-1:0];
    end

    assign o_onehot = o_valid ? (N'(1) << o_winner) : '0;

endmodule

// File: rtl/tribus_arbiter.sv
// Round-robin owner of a shared tristate bus: drives the bufif1 enables, caps each
// drive window at MAX_HOLD cycles and forces TURN_CYCLES idle cycles between owners.
module tribus_arbiter
    import tribus_pkg::*;
#(
    parameter int unsigned N           = 4,
    parameter int unsigned MAX_HOLD    = 8,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         gnt,
    output logic [N-1:0]         drv_en,
    output logic [$clog2(N)-1:0] owner,
    output logic                 bus_busy,
    output logic                 bus_idle
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned HW = $clog2(MAX_HOLD + 1);
    localparam int unsigned TW = $clog2(TURN_CYCLES + 1);
    localparam logic [HW-1:0] HoldLast = HW'(MAX_HOLD - 1);
    localparam logic [TW-1:0] TurnLast = TW'(TURN_CYCLES - 1);

    if (N < 2 || N > 16) begin : g_bad_n
        $error("tribus_arbiter: N must be in 2..16");
    end
    if (MAX_HOLD < 1) begin : g_bad_hold
        $error("tribus_arbiter: MAX_HOLD must be >= 1");
    end
    if (TURN_CYCLES < 1) begin : g_bad_turn
        $error("tribus_arbiter: TURN_CYCLES must be >= 1");
    end

    state_e        r_state, w_state_nxt;
    logic [N-1:0]  r_gnt, w_gnt_nxt;
    logic [IW-1:0] r_owner, w_owner_nxt;
    logic [IW-1:0] r_last, w_last_nxt;
    logic [HW-1:0] r_hold, w_hold_nxt;
    logic [TW-1:0] r_turn, w_turn_nxt;

    logic          w_pick_valid;
    logic [IW-1:0] w_pick_winner;
    logic [N-1:0]  w_pick_onehot;

    tribus_rr_pick #(
        .N  (N),
        .IW (IW)
    ) u_pick (
        .i_req    (req),
        .i_last   (r_last),
        .o_valid  (w_pick_valid),
        .o_winner (w_pick_winner),
        .o_onehot (w_pick_onehot)
    );

    // Next-state logic: arbitrate in IDLE or on the last TURN cycle, release on drop/limit.
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_hold_nxt  = r_hold;
        w_turn_nxt  = r_turn;
        unique case (r_state)
            StIdle: begin
                if (w_pick_valid) begin
                    w_state_nxt = StDrive;
                    w_gnt_nxt   = w_pick_onehot;
                    w_owner_nxt = w_pick_winner;
                    w_last_nxt  = w_pick_winner;
                    w_hold_nxt  = '0;
                end
            end
            StDrive: begin
                if (!req[r_owner] || r_hold == HoldLast) begin
                    w_state_nxt = StTurn;
                    w_gnt_nxt   = '0;
                    w_turn_nxt  = '0;
                end else begin
                    w_hold_nxt = r_hold + 1'b1;
                end
            end
            StTurn: begin
                if (r_turn == TurnLast) begin
                    if (w_pick_valid) begin
                        w_state_nxt = StDrive;
                        w_gnt_nxt   = w_pick_onehot;
                        w_owner_nxt = w_pick_winner;
                        w_last_nxt  = w_pick_winner;
                        w_hold_nxt  = '0;
                    end else begin
                        w_state_nxt = StIdle;
                    end
                end else begin
                    w_turn_nxt = r_turn + 1'b1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    // State and output registers; reset leaves last at N-1 so req[0] wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_gnt   <= '0;
            r_owner <= '0;
            r_last  <= IW'(N - 1);
            r_hold  <= '0;
            r_turn  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            r_hold  <= w_hold_nxt;
            r_turn  <= w_turn_nxt;
        end
    end

    assign gnt      = r_gnt;
    assign drv_en   = r_gnt;
    assign owner    = r_owner;
    assign bus_busy = |r_gnt;
    assign bus_idle = (r_state == StIdle);

endmodule

// File: tb/tb_tribus_arbiter.sv
// Self-checking bench for tribus_arbiter against a window/gap level reference model.
module tb_tribus_arbiter;

    localparam int N           = 4;
    localparam int MAX_HOLD    = 8;
    localparam int TURN_CYCLES = 1;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [N-1:0] gnt;
    logic [N-1:0] drv_en;
    logic [1:0]   owner;
    logic         bus_busy;
    logic         bus_idle;

    tribus_arbiter #(
        .N           (N),
        .MAX_HOLD    (MAX_HOLD),
        .TURN_CYCLES (TURN_CYCLES)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .gnt      (gnt),
        .drv_en   (drv_en),
        .owner    (owner),
        .bus_busy (bus_busy),
        .bus_idle (bus_idle)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model: m_cur = owning requester or -1; m_win = cycles already driven in the
    // current window; m_gap = remaining idle turnaround cycles; m_last = last owner.
    int m_cur   = -1;
    int m_win   = 0;
    int m_gap   = 0;
    int m_last  = N - 1;
    int m_owner = 0;
    logic [N-1:0] prev_drv = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Give the bus to the first requester after the previous owner, cyclically.
    task automatic model_arbitrate();
        m_cur = -1;
        for (int k = 1; k <= N; k++) begin
            int idx;
            idx = (m_last + k) % N;
            if (m_cur < 0 && req[idx]) m_cur = idx;
        end
        if (m_cur >= 0) begin
            m_win   = 1;
            m_last  = m_cur;
            m_owner = m_cur;
        end
    endtask

    // Advance the model for the coming edge, clock the DUT, compare mid-cycle.
    task automatic step();
        logic [N-1:0] exp_gnt;
        if (rst) begin
            m_cur = -1; m_win = 0; m_gap = 0; m_last = N - 1; m_owner = 0;
        end else if (m_cur >= 0) begin
            if (!req[m_cur] || m_win == MAX_HOLD) begin
                m_cur = -1;
                m_gap = TURN_CYCLES;
            end else begin
                m_win++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
            if (m_gap == 0) model_arbitrate();
        end else begin
            model_arbitrate();
        end
        @(posedge clk);
        @(negedge clk);
        exp_gnt = (m_cur >= 0) ? (N'(1) << m_cur) : '0;
        check("gnt", 32'(gnt), 32'(exp_gnt));
        check("drv_en", 32'(drv_en), 32'(exp_gnt));
        check("owner", 32'(owner), 32'(m_owner));
        check("bus_busy", 32'(bus_busy), 32'(m_cur >= 0));
        check("bus_idle", 32'(bus_idle), 32'(m_cur < 0 && m_gap == 0));
        check("onehot0", 32'($onehot0(drv_en)), 32'd1);
        check("rise_fall", 32'((|(drv_en & ~prev_drv)) && (|(prev_drv & ~drv_en))), 32'd0);
        prev_drv = drv_en;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int found;

    initial begin
        rst = 1'b1;
        req = '0;
        // Reset then quiet bus
        run(3);
        rst = 1'b0;
        run(10);

        // Single short request
        req = 4'b0100;
        run(3);
        req = '0;
        run(5);

        // Hold limit on a lone requester
        req = 4'b0001;
        run(20);
        req = '0;
        run(4);

        // Full rotation
        req = 4'b1111;
        run(45);
        req = '0;
        run(4);

        // Fairness after reset, then req[0] joins during owner 3's window
        rst = 1'b1;
        run(2);
        rst = 1'b0;
        req = 4'b1010;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step();
            if (m_cur == 3) found = 1;
        end
        check("wait_owner3", 32'(found), 32'd1);
        run(2);
        req = 4'b1011;
        run(40);
        req = '0;
        run(4);

        // Reset in the middle of owner 2's window
        req = 4'b0100;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            step();
            if (m_cur == 2) found = 1;
        end
        check("wait_owner2", 32'(found), 32'd1);
        run(2);
        req = 4'b0110;
        rst = 1'b1;
        run(1);
        check("rst_drv_en", 32'(drv_en), 32'd0);
        check("rst_idle", 32'(bus_idle), 32'd1);
        rst = 1'b0;
        run(1);
        check("post_rst_owner", 32'(owner), 32'd1);
        run(5);

        // Random traffic with occasional resets
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 7) == 0) req = N'($urandom);
            rst = ($urandom_range(0, 59) == 0);
            step();
        end
        rst = 1'b0;
        req = '0;
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
